// File: rtl/difftest_run_ctrl.sv
// difftest_run_ctrl
//   Run sequencer for the difftest simulation top. It holds the DUT in reset for a fixed
//   number of cycles and performs a single init handshake with the checker. It then steps
//   the DUT one gated cycle at a time, with a step handshake after each cycle. UART
//   characters go into a small FIFO. The run ends on a good trap, a checker mismatch or the
//   cycle limit, and a sticky finish flag is raised together with a cause code.
// Ports
//   clock, reset           controller clock; synchronous active-low reset
//   cfg_max_cycles         cycle limit (0 = unlimited), sampled every cycle
//   dut_reset, dut_clk_en  DUT reset (active high) and per-cycle clock enable
//   init_req / init_ack    one-shot init handshake with the checker
//   step_req / step_ack    per-cycle step handshake; step_fail qualified by step_ack
//   uart_valid, uart_ch    DUT UART output; bit 7 set marks a good trap
//   uart_out_*             FIFO head with valid/ready
//   cycle_count            DUT cycles executed since reset
//   finish, finish_code    sticky completion; 1 good trap, 2 step fail, 3 max cycles
module difftest_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 50,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CNT_W        = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      cfg_max_cycles,
  output logic             dut_reset,
  output logic             dut_clk_en,
  output logic             init_req,
  input  logic             init_ack,
  output logic             step_req,
  input  logic             step_ack,
  input  logic             step_fail,
  input  logic             uart_valid,
  input  logic [7:0]       uart_ch,
  output logic             uart_out_valid,
  output logic [7:0]       uart_out_ch,
  input  logic             uart_out_ready,
  output logic [CNT_W-1:0] cycle_count,
  output logic             finish,
  output logic [1:0]       finish_code
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned CMP_W  = (CNT_W > 32) ? CNT_W : 32;

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                trap_flag;
  logic [1:0]          code_r;

  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr_n;
  logic [PTR_W-1:0]    rd_ptr_n;
  logic [FCNT_W-1:0]   fifo_count;
  logic [FCNT_W-1:0]   fifo_count_n;
  logic [7:0]          head_n;
  logic                push;
  logic                pop;
  logic                trap_now;
  logic                fifo_room;
  logic                limit_hit;

  // FIFO next-state and step decision helpers
  always_comb begin
    push         = dut_clk_en && uart_valid && !uart_ch[7];
    trap_now     = dut_clk_en && uart_valid && uart_ch[7];
    pop          = uart_out_valid && uart_out_ready;
    wr_ptr_n     = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_n     = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    fifo_count_n = fifo_count;
    case ({push, pop})
      2'b10:   fifo_count_n = fifo_count + FCNT_W'(1);
      2'b01:   fifo_count_n = fifo_count - FCNT_W'(1);
      default: fifo_count_n = fifo_count;
    endcase
    // A char written this cycle into the slot that becomes the head bypasses the array
    head_n    = (push && (rd_ptr_n == wr_ptr)) ? uart_ch : mem[rd_ptr_n];
    fifo_room = fifo_count < FCNT_W'(FIFO_DEPTH);
    limit_hit = (cfg_max_cycles != 32'd0) &&
                (CMP_W'(cycle_count) >= CMP_W'(cfg_max_cycles));
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= uart_ch;
    end
  end

  // Run sequencer, FIFO pointers and all registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= S_HOLD;
      hold_cnt       <= '0;
      trap_flag      <= 1'b0;
      code_r         <= 2'd0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      dut_reset      <= 1'b1;
      dut_clk_en     <= 1'b0;
      init_req       <= 1'b0;
      step_req       <= 1'b0;
      uart_out_valid <= 1'b0;
      uart_out_ch    <= 8'd0;
      cycle_count    <= '0;
      finish         <= 1'b0;
      finish_code    <= 2'd0;
    end else begin
      wr_ptr         <= wr_ptr_n;
      rd_ptr         <= rd_ptr_n;
      fifo_count     <= fifo_count_n;
      uart_out_valid <= (fifo_count_n != FCNT_W'(0));
      uart_out_ch    <= head_n;
      dut_clk_en     <= 1'b0;
      if (trap_now) begin
        trap_flag <= 1'b1;
      end

      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
            dut_reset <= 1'b0;
            init_req  <= 1'b1;
            state     <= S_INIT;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_INIT: begin
          if (init_ack) begin
            init_req <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          // One DUT cycle only when the FIFO can absorb a char from it
          if (fifo_room) begin
            dut_clk_en  <= 1'b1;
            cycle_count <= cycle_count + CNT_W'(1);
            step_req    <= 1'b1;
            state       <= S_STEP;
          end
        end
        S_STEP: begin
          // The trap char may arrive on the same edge as the ack, hence trap_now
          if (step_ack) begin
            step_req <= 1'b0;
            if (step_fail) begin
              code_r <= 2'd2;
              state  <= S_DRAIN;
            end else if (trap_flag || trap_now) begin
              code_r <= 2'd1;
              state  <= S_DRAIN;
            end else if (limit_hit) begin
              code_r <= 2'd3;
              state  <= S_DRAIN;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_DRAIN: begin
          if (fifo_count == FCNT_W'(0)) begin
            finish      <= 1'b1;
            finish_code <= code_r;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_difftest_run_ctrl.sv
// tb_difftest_run_ctrl
//   Directed bench for difftest_run_ctrl. A checker/DUT emulator answers the handshakes
//   and supplies UART chars. A queue-based model tracks the FIFO contents, DUT cycle
//   count and reset timing, and its values are compared with the outputs on every
//   negative edge. Each scenario also checks hand-computed literal results.
module tb_difftest_run_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cfg_max_cycles = 32'd0;
  logic        dut_reset, dut_clk_en, init_req, step_req;
  logic        init_ack = 1'b1;
  logic        step_ack = 1'b0;
  logic        step_fail = 1'b0;
  logic        uart_valid = 1'b0;
  logic [7:0]  uart_ch = 8'd0;
  logic        uart_out_valid;
  logic [7:0]  uart_out_ch;
  logic        uart_out_ready = 1'b1;
  logic [63:0] cycle_count;
  logic        finish;
  logic [1:0]  finish_code;

  always #5 clock = ~clock;

  difftest_run_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_max_cycles (cfg_max_cycles),
    .dut_reset      (dut_reset),
    .dut_clk_en     (dut_clk_en),
    .init_req       (init_req),
    .init_ack       (init_ack),
    .step_req       (step_req),
    .step_ack       (step_ack),
    .step_fail      (step_fail),
    .uart_valid     (uart_valid),
    .uart_ch        (uart_ch),
    .uart_out_valid (uart_out_valid),
    .uart_out_ch    (uart_out_ch),
    .uart_out_ready (uart_out_ready),
    .cycle_count    (cycle_count),
    .finish         (finish),
    .finish_code    (finish_code)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Emulator configuration
  logic [7:0] prog[$];
  int         ack_delay = 0;
  int         fail_at   = 0;
  int         wait_cnt  = 0;
  int         acks      = 0;
  int         pidx      = 0;

  // Model state
  logic [7:0] q[$];
  logic [7:0] popped[$];
  int         m_pulses = 0;
  int         rel      = 0;
  bit         was_reset = 1'b0;
  bit         chk_on    = 1'b0;
  bit         prev_en   = 1'b0;
  bit         prev_req  = 1'b0;
  bit         prev_ack  = 1'b0;
  bit         seen_fin  = 1'b0;
  logic [1:0] fin_code  = 2'd0;

  // Model update from the values the DUT sees at this edge
  always @(posedge clock) begin
    if (!reset) begin
      q.delete();
      popped.delete();
      m_pulses  = 0;
      rel       = 0;
      was_reset = 1'b1;
      seen_fin  = 1'b0;
      prev_en   = 1'b0;
      prev_req  = 1'b0;
      prev_ack  = 1'b0;
    end else begin
      was_reset = 1'b0;
      rel++;
      if (uart_out_valid && uart_out_ready && q.size() > 0) popped.push_back(q.pop_front());
      if (dut_clk_en && uart_valid && !uart_ch[7]) q.push_back(uart_ch);
    end
  end

  // Compare against the model, then drive checker/DUT-emulator responses
  always @(negedge clock) begin
    if (chk_on) begin
      if (dut_clk_en) m_pulses++;
      chk("dut_reset", 64'(dut_reset), 64'(rel < 50));
      chk("cycle_count", cycle_count, 64'(m_pulses));
      chk("out_valid", 64'(uart_out_valid), 64'(q.size() != 0));
      if (q.size() != 0) chk("out_ch", 64'(uart_out_ch), 64'(q[0]));
      if (was_reset) begin
        chk("rst_clk_en", 64'(dut_clk_en), 64'd0);
        chk("rst_init_req", 64'(init_req), 64'd0);
        chk("rst_step_req", 64'(step_req), 64'd0);
        chk("rst_out_ch", 64'(uart_out_ch), 64'd0);
        chk("rst_finish", 64'(finish), 64'd0);
        chk("rst_code", 64'(finish_code), 64'd0);
      end
      if (dut_clk_en) begin
        chk("en_single_cycle", 64'(prev_en), 64'd0);
        chk("en_with_step_req", 64'(step_req), 64'd1);
        chk("en_while_ack_wait", 64'(prev_req && !prev_ack), 64'd0);
      end
      if (seen_fin) begin
        chk("finish_sticky", 64'(finish), 64'd1);
        chk("code_held", 64'(finish_code), 64'(fin_code));
      end else if (finish === 1'b1) begin
        seen_fin = 1'b1;
        fin_code = finish_code;
      end
    end

    // DUT emulator: one program char per enabled DUT cycle
    uart_valid = 1'b0;
    uart_ch    = 8'd0;
    // Checker emulator: ack after ack_delay cycles of step_req, one-cycle pulse
    if (!reset) begin
      step_ack = 1'b0;
      step_fail = 1'b0;
      wait_cnt = 0;
      acks = 0;
      pidx = 0;
    end else begin
      if (dut_clk_en) begin
        if (pidx < prog.size()) begin
          uart_valid = 1'b1;
          uart_ch    = prog[pidx];
        end
        pidx++;
      end
      if (step_ack) begin
        step_ack  = 1'b0;
        step_fail = 1'b0;
      end else if (step_req) begin
        if (wait_cnt >= ack_delay) begin
          acks++;
          step_ack  = 1'b1;
          step_fail = (acks == fail_at);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
    prev_en  = dut_clk_en;
    prev_req = step_req;
    prev_ack = step_ack;
  end

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic wait_finish(input string name, input int lim);
    int n = 0;
    while (finish !== 1'b1 && n < lim) begin
      @(negedge clock);
      n++;
    end
    chk(name, 64'(finish), 64'd1);
  endtask

  task automatic chk_popped(input string name, input logic [7:0] exp[$]);
    chk(name, 64'(popped.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < popped.size(); i++) chk(name, 64'(popped[i]), 64'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp_chars[$];
    int hi, k_init, k_en, en_win;

    @(posedge clock); #1 chk_on = 1'b1;

    // 1: reset hold length, init handshake latency, two-cycle stepping
    ack_delay = 0; fail_at = 0; cfg_max_cycles = 32'd0; uart_out_ready = 1'b1;
    prog.delete();
    do_reset();
    hi = 0; k_init = -1; k_en = -1; en_win = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (dut_reset && k_init < 0) hi++;
      if (init_req && init_ack && k_init < 0) k_init = k;
      if (dut_clk_en && k_en < 0) k_en = k;
      if (dut_clk_en && k_en >= 0 && k < k_en + 20) en_win++;
    end
    chk("reset_hold_cycles", 64'(hi), 64'd50);
    chk("init_to_first_en", 64'(k_en - k_init), 64'd2);
    chk("pulses_in_20_cycles", 64'(en_win), 64'd10);
    chk("no_finish_unlimited", 64'(finish), 64'd0);

    // 2: 'H','i' then good trap
    @(posedge clock); #1;
    prog = '{8'h48, 8'h69, 8'h80};
    do_reset();
    wait_finish("trap_finish", 500);
    chk("trap_code", 64'(finish_code), 64'd1);
    chk("trap_count", cycle_count, 64'd3);
    exp_chars = '{8'h48, 8'h69};
    chk_popped("trap_chars", exp_chars);

    // 3: cycle limit 10, no trap
    @(posedge clock); #1;
    prog = '{8'h61, 8'h62};
    cfg_max_cycles = 32'd10;
    do_reset();
    wait_finish("max_finish", 500);
    chk("max_code", 64'(finish_code), 64'd3);
    chk("max_count", cycle_count, 64'd10);
    chk("max_pulses", 64'(m_pulses), 64'd10);

    // 4: slow checker, mismatch on the 4th step
    @(posedge clock); #1;
    prog.delete();
    cfg_max_cycles = 32'd0;
    ack_delay = 5; fail_at = 4;
    do_reset();
    wait_finish("fail_finish", 800);
    chk("fail_code", 64'(finish_code), 64'd2);
    chk("fail_count", cycle_count, 64'd4);

    // 5: consumer stalled, 9 chars then trap
    @(posedge clock); #1;
    ack_delay = 0; fail_at = 0;
    uart_out_ready = 1'b0;
    prog = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h80};
    do_reset();
    for (int n = 0; n < 300 && cycle_count != 64'd8; n++) @(negedge clock);
    repeat (30) @(negedge clock);
    chk("stall_count", cycle_count, 64'd8);
    chk("stall_valid", 64'(uart_out_valid), 64'd1);
    chk("stall_head", 64'(uart_out_ch), 64'h41);
    chk("stall_no_finish", 64'(finish), 64'd0);
    @(posedge clock); #1 uart_out_ready = 1'b1;
    wait_finish("stall_finish", 500);
    chk("stall_code", 64'(finish_code), 64'd1);
    chk("stall_final_count", cycle_count, 64'd10);
    exp_chars = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
    chk_popped("stall_chars", exp_chars);

    // 6: reset while a step request is outstanding
    @(posedge clock); #1;
    prog = '{8'h5a};
    ack_delay = 1000;
    do_reset();
    for (int n = 0; n < 300 && !(step_req && !dut_clk_en); n++) @(negedge clock);
    chk("midstep_req_seen", 64'(step_req), 64'd1);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    chk("mid_dut_reset", 64'(dut_reset), 64'd1);
    chk("mid_clk_en", 64'(dut_clk_en), 64'd0);
    chk("mid_init_req", 64'(init_req), 64'd0);
    chk("mid_step_req", 64'(step_req), 64'd0);
    chk("mid_out_valid", 64'(uart_out_valid), 64'd0);
    chk("mid_out_ch", 64'(uart_out_ch), 64'd0);
    chk("mid_count", cycle_count, 64'd0);
    chk("mid_finish", 64'(finish), 64'd0);
    chk("mid_code", 64'(finish_code), 64'd0);
    reset = 1'b1;
    ack_delay = 0;
    repeat (10) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
